mdu_ctrl: RTL and testbench

- Multiply/divide sequencer plus HI/LO register owner for the EXE stage.
- Accepts the one-hot mult_div_op decoded in ID and runs a fixed-latency multiply or an iterative radix-2 restoring divide.
- Stalls EXE through a ready handshake and serves MFHI/MFLO/MTHI/MTLO.
- Commits HI/LO only when the instruction leaves EXE un-flushed, so a WB exception/ERET flush never leaves a partial update.

---
 rtl/mdu_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mdu_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// EXE-stage multiply/divide sequencer and owner of the architectural HI/LO pair.
// Multiply has fixed latency; divide is radix-2 restoring, one quotient bit per cycle.
module mdu_ctrl #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_valid_in,
  input  logic [7:0]  exe_mult_div_op,
  input  logic [31:0] exe_src1_in,
  input  logic [31:0] exe_src2_in,
  input  logic        exe_go_in,
  input  logic        exe_cancel_in,
  output logic        mdu_ready_out,
  output logic        mdu_busy_out,
  output logic [31:0] mf_res_out,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int unsigned CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       opa, opb;
  logic [32:0]       rem;
  logic              sgn_op, q_neg, r_neg;
  logic [31:0]       tmp_hi, tmp_lo;
  logic [31:0]       hi, lo;

  logic        is_mul_op, is_div_op, signed_op, start;
  logic        mul_last, div_last;
  logic [31:0] abs1, abs2;
  logic [63:0] prod;
  logic [33:0] trial;
  logic        q_bit;
  logic [32:0] rem_nxt;
  logic [31:0] q_raw, q_fix, r_fix;

  assign is_mul_op = exe_mult_div_op[0] | exe_mult_div_op[1];
  assign is_div_op = exe_mult_div_op[2] | exe_mult_div_op[3];
  assign signed_op = exe_mult_div_op[0] | exe_mult_div_op[2];
  assign start     = exe_valid_in & (is_mul_op | is_div_op) & ~exe_cancel_in & (state == IDLE);
  assign mul_last  = (cnt == CNT_W'(MUL_CYCLES - 1));
  assign div_last  = (cnt == CNT_W'(DIV_CYCLES - 1));

  assign abs1 = (signed_op & exe_src1_in[31]) ? -exe_src1_in : exe_src1_in;
  assign abs2 = (signed_op & exe_src2_in[31]) ? -exe_src2_in : exe_src2_in;

  // Operands are extended straight to 64 bits; the low 64 product bits equal
  // those of the 33x33 sign/zero-extended product.
  always_comb begin
    prod = {{32{sgn_op & opa[31]}}, opa} * {{32{sgn_op & opb[31]}}, opb};
  end

  // One restoring step: opa shifts the dividend out MSB-first and the quotient in.
  always_comb begin
    trial   = {rem, opa[31]};
    q_bit   = (trial >= {2'b00, opb});
    rem_nxt = q_bit ? (trial[32:0] - {1'b0, opb}) : trial[32:0];
    q_raw   = {opa[30:0], q_bit};
    q_fix   = q_neg ? -q_raw : q_raw;
    r_fix   = r_neg ? -rem_nxt[31:0] : rem_nxt[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (exe_cancel_in) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = is_mul_op ? MUL : DIV;
        MUL:     if (mul_last) state_nxt = DONE;
        DIV:     if (div_last) state_nxt = DONE;
        DONE:    if (exe_go_in) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    mdu_ready_out = 1'b1;
    mdu_busy_out  = (state != IDLE);
    case (state)
      IDLE:    mdu_ready_out = ~start;
      MUL:     mdu_ready_out = 1'b0;
      DIV:     mdu_ready_out = 1'b0;
      DONE:    mdu_ready_out = 1'b1;
      default: mdu_ready_out = 1'b1;
    endcase
  end

  // A cancelled cycle touches nothing but the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      rem    <= '0;
      sgn_op <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      tmp_hi <= '0;
      tmp_lo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (!exe_cancel_in) begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= '0;
            sgn_op <= signed_op;
            opa    <= is_mul_op ? exe_src1_in : abs1;
            opb    <= is_mul_op ? exe_src2_in : abs2;
            rem    <= '0;
            q_neg  <= signed_op & (exe_src1_in[31] ^ exe_src2_in[31]);
            r_neg  <= signed_op & exe_src1_in[31];
          end else if (exe_valid_in && exe_go_in) begin
            if (exe_mult_div_op[6]) hi <= exe_src1_in;
            if (exe_mult_div_op[7]) lo <= exe_src1_in;
          end
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          if (mul_last) begin
            tmp_hi <= prod[63:32];
            tmp_lo <= prod[31:0];
          end
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          rem <= rem_nxt;
          opa <= q_raw;
          if (div_last) begin
            tmp_lo <= q_fix;
            tmp_hi <= r_fix;
          end
        end
        DONE: begin
          if (exe_go_in) begin
            hi <= tmp_hi;
            lo <= tmp_lo;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mf_res_out = '0;
    if (exe_mult_div_op[4])      mf_res_out = hi;
    else if (exe_mult_div_op[5]) mf_res_out = lo;
  end

  assign hi_out = hi;
  assign lo_out = lo;

  // While busy, EXE is stalled on the mult/div that started it; nothing else may appear.
  a_no_new_op_while_busy: assert property (@(posedge clk) disable iff (rst)
    (state != IDLE && exe_valid_in && !exe_cancel_in) |-> (exe_mult_div_op[3:0] != 4'b0000));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vectors plus randomized ops checked
// against an arithmetic reference of HI/LO semantics.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid;
  logic [7:0]  op;
  logic [31:0] src1, src2;
  logic        go, cancel;
  logic        ready, busy;
  logic [31:0] mf_res, hi, lo;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mdu_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .exe_valid_in    (valid),
    .exe_mult_div_op (op),
    .exe_src1_in     (src1),
    .exe_src2_in     (src2),
    .exe_go_in       (go),
    .exe_cancel_in   (cancel),
    .mdu_ready_out   (ready),
    .mdu_busy_out    (busy),
    .mf_res_out      (mf_res),
    .hi_out          (hi),
    .lo_out          (lo)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // HI/LO outcome of a mult/multu/div/divu from plain arithmetic.
  function automatic void ref_muldiv(input int unsigned opi, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] rhi, output logic [31:0] rlo);
    logic [63:0] p;
    longint unsigned ua, ub, q, r;
    bit na, nb;
    p = '0;
    if (opi == 0) begin
      p = 64'(longint'($signed(a)) * longint'($signed(b)));
      rhi = p[63:32]; rlo = p[31:0];
    end else if (opi == 1) begin
      p = {32'b0, a} * {32'b0, b};
      rhi = p[63:32]; rlo = p[31:0];
    end else begin
      na = (opi == 2) && a[31];
      nb = (opi == 2) && b[31];
      ua = na ? (64'h1_0000_0000 - {32'b0, a}) : {32'b0, a};
      ub = nb ? (64'h1_0000_0000 - {32'b0, b}) : {32'b0, b};
      if (ub == 0) begin
        q = 64'hFFFF_FFFF; r = ua;
      end else begin
        q = ua / ub; r = ua % ub;
      end
      if (na ^ nb) q = -q;
      if (na) r = -r;
      rlo = q[31:0]; rhi = r[31:0];
    end
  endfunction

  task automatic idle_inputs();
    valid = 1'b0; op = '0; src1 = '0; src2 = '0; go = 1'b0; cancel = 1'b0;
  endtask

  // Issues a mult/div, holds DONE for 'hold' cycles, then lets it leave EXE.
  task automatic run_muldiv(input int unsigned opi, input logic [31:0] a, input logic [31:0] b,
                            input int unsigned hold, output int unsigned stalls, output bit timed_out);
    @(negedge clk);
    valid = 1'b1; op = 8'(1 << opi); src1 = a; src2 = b; go = 1'b0; cancel = 1'b0;
    stalls = 0; timed_out = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (ready) begin timed_out = 1'b0; break; end
      stalls++;
      @(negedge clk);
    end
    if (!timed_out) begin
      repeat (hold) @(negedge clk);
      go = 1'b1;
      @(negedge clk);
    end
    idle_inputs();
    #1;
  endtask

  task automatic do_mt(input bit to_lo, input logic [31:0] v);
    @(negedge clk);
    valid = 1'b1; op = to_lo ? 8'h80 : 8'h40; src1 = v; go = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (mf_res !== 32'h0) begin errors++; $display("FAIL reset_mf: got %h expected 0", mf_res); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult();
    int unsigned st; bit to;
    run_muldiv(0, 32'hFFFF_FFFD, 32'd5, 0, st, to);
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFF1;
    checks++; if (to) begin errors++; $display("FAIL mult_timeout: ready never rose"); end
    checks++; if (st !== 3) begin errors++; $display("FAIL mult_stall: got %0d expected 3", st); end
    checks++; if (hi !== m_hi) begin errors++; $display("FAIL mult_hi: got %h expected %h", hi, m_hi); end
    checks++; if (lo !== m_lo) begin errors++; $display("FAIL mult_lo: got %h expected %h", lo, m_lo); end
    @(negedge clk);
    valid = 1'b1; op = 8'h20; #1;
    checks++; if (mf_res !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mflo: got %h expected fffffff1", mf_res); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mflo_ready: got %b expected 1", ready); end
    idle_inputs();
  endtask

  task automatic test_div_vectors();
    logic [31:0] va [4] = '{32'd100, 32'hFFFF_FFF9, 32'h1234_5678, 32'h8000_0000};
    logic [31:0] vb [4] = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] el [4] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] eh [4] = '{32'd2, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0};
    int unsigned vo [4] = '{3, 2, 3, 2};
    int unsigned st; bit to;
    for (int i = 0; i < 4; i++) begin
      run_muldiv(vo[i], va[i], vb[i], 0, st, to);
      m_hi = eh[i]; m_lo = el[i];
      checks++; if (to) begin errors++; $display("FAIL div%0d_timeout: ready never rose", i); end
      checks++; if (st !== 33) begin errors++; $display("FAIL div%0d_stall: got %0d expected 33", i, st); end
      checks++; if (lo !== el[i]) begin errors++; $display("FAIL div%0d_lo: got %h expected %h", i, lo, el[i]); end
      checks++; if (hi !== eh[i]) begin errors++; $display("FAIL div%0d_hi: got %h expected %h", i, hi, eh[i]); end
    end
  endtask

  task automatic test_random();
    int unsigned st, opi, sel; bit to;
    logic [31:0] a, b, eh, el, v;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        v = $urandom;
        do_mt(sel[0], v);
        if (sel[0]) m_lo = v; else m_hi = v;
        checks++; if (hi !== m_hi) begin errors++; $display("FAIL rnd_mt_hi[%0d]: got %h expected %h", n, hi, m_hi); end
        checks++; if (lo !== m_lo) begin errors++; $display("FAIL rnd_mt_lo[%0d]: got %h expected %h", n, lo, m_lo); end
      end else begin
        opi = $urandom_range(0, 3);
        a = $urandom;
        case ($urandom_range(0, 5))
          0:       b = 32'h0;
          1:       b = 32'($urandom_range(1, 15));
          2:       b = 32'hFFFF_FFFF;
          default: b = $urandom;
        endcase
        run_muldiv(opi, a, b, $urandom_range(0, 2), st, to);
        ref_muldiv(opi, a, b, eh, el);
        m_hi = eh; m_lo = el;
        checks++; if (to) begin errors++; $display("FAIL rnd_timeout[%0d]: ready never rose", n); end
        checks++; if (st !== ((opi < 2) ? 3 : 33)) begin errors++; $display("FAIL rnd_stall[%0d] op%0d: got %0d", n, opi, st); end
        checks++; if (hi !== eh) begin errors++; $display("FAIL rnd_hi[%0d] op%0d %h,%h: got %h expected %h", n, opi, a, b, hi, eh); end
        checks++; if (lo !== el) begin errors++; $display("FAIL rnd_lo[%0d] op%0d %h,%h: got %h expected %h", n, opi, a, b, lo, el); end
      end
      @(negedge clk);
      valid = 1'b1; op = 8'h10; #1;
      checks++; if (mf_res !== m_hi) begin errors++; $display("FAIL rnd_mfhi[%0d]: got %h expected %h", n, mf_res, m_hi); end
      idle_inputs();
    end
  endtask

  task automatic test_cancel();
    do_mt(1'b0, 32'h0000_AAAA); m_hi = 32'h0000_AAAA;
    do_mt(1'b1, 32'h5555_1234); m_lo = 32'h5555_1234;
    @(negedge clk);
    valid = 1'b1; op = 8'h04; src1 = 32'd1000; src2 = 32'd3;
    repeat (11) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cancel_busy_before: got %b expected 1", busy); end
    cancel = 1'b1;
    @(negedge clk);
    idle_inputs(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy_after: got %b expected 0", busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL cancel_ready: got %b expected 1", ready); end
    checks++; if (hi !== m_hi) begin errors++; $display("FAIL cancel_hi: got %h expected %h", hi, m_hi); end
    checks++; if (lo !== m_lo) begin errors++; $display("FAIL cancel_lo: got %h expected %h", lo, m_lo); end
    valid = 1'b1; op = 8'h80; go = 1'b1; src1 = 32'h0;
    repeat (40) @(negedge clk);
    valid = 1'b0; op = '0; go = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_late_busy: got %b expected 0", busy); end
    m_lo = 32'h0;
    checks++; if (hi !== m_hi) begin errors++; $display("FAIL cancel_late_hi: got %h expected %h", hi, m_hi); end
  endtask

  task automatic test_done_hold();
    bit seen;
    @(negedge clk);
    valid = 1'b1; op = 8'h02; src1 = 32'h0001_0000; src2 = 32'h0003_0000;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ready) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL hold_timeout: ready never rose"); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL hold_ready[%0d]: got %b expected 1", i, ready); end
      checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL hold_hilo[%0d]: got %h/%h expected %h/%h", i, hi, lo, m_hi, m_lo); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy[%0d]: got %b expected 1", i, busy); end
      @(negedge clk); #1;
    end
    go = 1'b1; cancel = 1'b1;
    @(negedge clk);
    idle_inputs(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_cancel_busy: got %b expected 0", busy); end
    checks++; if (hi !== m_hi) begin errors++; $display("FAIL hold_cancel_hi: got %h expected %h", hi, m_hi); end
    checks++; if (lo !== m_lo) begin errors++; $display("FAIL hold_cancel_lo: got %h expected %h", lo, m_lo); end
  endtask

  task automatic test_reset_mid();
    do_mt(1'b0, 32'hDEAD_0001); m_hi = 32'hDEAD_0001;
    do_mt(1'b1, 32'hBEEF_0002); m_lo = 32'hBEEF_0002;
    @(negedge clk);
    valid = 1'b1; op = 8'h01; src1 = 32'd7; src2 = 32'd9;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
    idle_inputs(); rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", ready); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo: got %h expected 0", lo); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_mult();
    test_div_vectors();
    test_random();
    test_cancel();
    test_done_hold();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
